// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with arbitrary depth (non-power-of-2 allowed),
// programmable almost-full/almost-empty thresholds, an occupancy count and an
// optional first-word-fall-through read port.
module sync_fifo_param #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AFULL_TH   = 7,
  parameter int AEMPTY_TH  = 1,
  parameter int FWFT       = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [FIFO_WIDTH-1:0]            data_in,
  input  logic                             wr_en,
  input  logic                             rd_en,
  output logic [FIFO_WIDTH-1:0]            data_out,
  output logic                             wr_ack,
  output logic                             overflow,
  output logic                             underflow,
  output logic                             full,
  output logic                             empty,
  output logic                             almostfull,
  output logic                             almostempty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  count
);

  // Count must hold the value FIFO_DEPTH itself, pointers only 0..FIFO_DEPTH-1.
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AFULL_C    = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C   = CW'(AEMPTY_TH);
  localparam logic [PW-1:0] LAST_PTR   = PW'(FIFO_DEPTH - 1);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  // Parameter legality is checked once at elaboration; there are no runtime checks.
  generate
    if (FIFO_DEPTH < 2) begin : g_bad_depth
      $error("sync_fifo_param: FIFO_DEPTH (%0d) must be >= 2", FIFO_DEPTH);
    end
    if ((AFULL_TH < 1) || (AFULL_TH > FIFO_DEPTH - 1)) begin : g_bad_afull
      $error("sync_fifo_param: AFULL_TH (%0d) must be in 1..FIFO_DEPTH-1", AFULL_TH);
    end
    if ((AEMPTY_TH < 1) || (AEMPTY_TH > FIFO_DEPTH - 1)) begin : g_bad_aempty
      $error("sync_fifo_param: AEMPTY_TH (%0d) must be in 1..FIFO_DEPTH-1", AEMPTY_TH);
    end
    if ((FWFT != 0) && (FWFT != 1)) begin : g_bad_fwft
      $error("sync_fifo_param: FWFT (%0d) must be 0 or 1", FWFT);
    end
  endgenerate

  // Storage; deliberately has no reset so it can map onto RAM resources.
  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          wr_ack_reg;
  logic          overflow_reg;
  logic          underflow_reg;

  logic wr_accept;
  logic rd_accept;
  logic full_int;
  logic empty_int;

  // Status flags come straight from the registered count, so they never glitch
  // on the request inputs.
  assign full_int    = (count_reg == DEPTH_C);
  assign empty_int   = (count_reg == '0);
  assign full        = full_int;
  assign empty       = empty_int;
  assign almostfull  = (count_reg >= AFULL_C) && !full_int;
  assign almostempty = !empty_int && (count_reg <= AEMPTY_C);
  assign count       = count_reg;

  // Acceptance is judged on the pre-edge occupancy: a full FIFO never takes a
  // write even if a read frees a slot in the same cycle, and an empty FIFO never
  // serves a read from a word being written in the same cycle.
  assign wr_accept = wr_en && !full_int;
  assign rd_accept = rd_en && !empty_int;

  // Next pointer/count values; pointers wrap explicitly at the last slot so
  // any depth works, not only powers of two.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;

    if (wr_accept) begin
      wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : (wr_ptr_reg + PTR_ONE);
    end
    if (rd_accept) begin
      rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : (rd_ptr_reg + PTR_ONE);
    end

    unique case ({wr_accept, rd_accept})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  // Pointer, occupancy and one-cycle handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      wr_ack_reg    <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      wr_ack_reg    <= wr_accept;
      overflow_reg  <= wr_en && !wr_accept;
      underflow_reg <= rd_en && !rd_accept;
    end
  end

  assign wr_ack    = wr_ack_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

  // Write port into storage.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr_reg] <= data_in;
    end
  end

  // Read port: either the head word shown combinationally (fall-through) or a
  // registered copy taken on each accepted read that holds between reads.
  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = empty_int ? '0 : mem[rd_ptr_reg];
    end else begin : g_registered
      logic [FIFO_WIDTH-1:0] rd_data_reg;

      // Capture the head word on an accepted read; otherwise hold the last one.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data_reg <= '0;
        end else if (rd_accept) begin
          rd_data_reg <= mem[rd_ptr_reg];
        end
      end

      assign data_out = rd_data_reg;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: two FIFO instances driven by the same request stream.
//  u_a: DEPTH=8, AFULL_TH=6, AEMPTY_TH=2, registered read
//  u_b: DEPTH=5, AFULL_TH=3, AEMPTY_TH=1, first-word-fall-through
// Each cycle's request is run through a queue-based reference model, and the
// predicted post-edge response is pushed to a per-instance scoreboard queue;
// independent monitors pop and compare on the falling edge.
module tb_sync_fifo_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data_in;
  logic        wr_en;
  logic        rd_en;

  logic [15:0] dout_a, dout_b;
  logic        ack_a, ovf_a, udf_a, full_a, empty_a, af_a, ae_a;
  logic        ack_b, ovf_b, udf_b, full_b, empty_b, af_b, ae_b;
  logic [3:0]  count_a;
  logic [2:0]  count_b;

  always #5 clk = ~clk;

  sync_fifo_param #(
    .FIFO_WIDTH(16), .FIFO_DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(2), .FWFT(0)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .data_out(dout_a), .wr_ack(ack_a), .overflow(ovf_a), .underflow(udf_a),
    .full(full_a), .empty(empty_a), .almostfull(af_a), .almostempty(ae_a),
    .count(count_a)
  );

  sync_fifo_param #(
    .FIFO_WIDTH(16), .FIFO_DEPTH(5), .AFULL_TH(3), .AEMPTY_TH(1), .FWFT(1)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .data_out(dout_b), .wr_ack(ack_b), .overflow(ovf_b), .underflow(udf_b),
    .full(full_b), .empty(empty_b), .almostfull(af_b), .almostempty(ae_b),
    .count(count_b)
  );

  typedef struct {
    int          tag;
    logic        wr_ack;
    logic        ovf;
    logic        udf;
    int          cnt;
    logic [15:0] dout;
  } exp_t;

  exp_t        exp_a[$];
  exp_t        exp_b[$];
  logic [15:0] qa[$];
  logic [15:0] qb[$];
  logic [15:0] last_a = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Drive one request, predict the response after the next edge, then advance.
  task automatic step(input logic w, input logic r, input logic [15:0] d);
    exp_t ea;
    exp_t eb;
    logic wa, ra, wb, rb;
    wr_en   = w;
    rd_en   = r;
    data_in = d;

    wa = w && (qa.size() < 8);
    ra = r && (qa.size() > 0);
    if (ra) last_a = qa.pop_front();
    if (wa) qa.push_back(d);
    ea.tag = cyc; ea.wr_ack = wa; ea.ovf = w && !wa; ea.udf = r && !ra;
    ea.cnt = qa.size(); ea.dout = last_a;
    exp_a.push_back(ea);

    wb = w && (qb.size() < 5);
    rb = r && (qb.size() > 0);
    if (rb) void'(qb.pop_front());
    if (wb) qb.push_back(d);
    eb.tag = cyc; eb.wr_ack = wb; eb.ovf = w && !wb; eb.udf = r && !rb;
    eb.cnt = qb.size(); eb.dout = (qb.size() > 0) ? qb[0] : 16'h0000;
    exp_b.push_back(eb);

    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tagname);
    chk({tagname, ".a.count"}, count_a, 0);
    chk({tagname, ".a.empty"}, empty_a, 1);
    chk({tagname, ".a.full"},  full_a,  0);
    chk({tagname, ".a.af"},    af_a,    0);
    chk({tagname, ".a.ae"},    ae_a,    0);
    chk({tagname, ".a.ack"},   ack_a,   0);
    chk({tagname, ".a.ovf"},   ovf_a,   0);
    chk({tagname, ".a.udf"},   udf_a,   0);
    chk({tagname, ".a.dout"},  dout_a,  0);
    chk({tagname, ".b.count"}, count_b, 0);
    chk({tagname, ".b.empty"}, empty_b, 1);
    chk({tagname, ".b.ack"},   ack_b,   0);
    chk({tagname, ".b.dout"},  dout_b,  0);
  endtask

  // Asynchronous reset asserted between edges; state must clear immediately.
  task automatic do_reset();
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    qa.delete();
    qb.delete();
    last_a = '0;
    #1;
    check_idle("midrst");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor for the registered-read instance.
  always @(negedge clk) begin : mon_a
    exp_t e;
    while ((exp_a.size() > 0) && (exp_a[0].tag < cyc)) begin
      e = exp_a.pop_front();
      chk("a.wr_ack",    ack_a,   e.wr_ack);
      chk("a.overflow",  ovf_a,   e.ovf);
      chk("a.underflow", udf_a,   e.udf);
      chk("a.count",     count_a, e.cnt);
      chk("a.full",      full_a,  (e.cnt == 8));
      chk("a.empty",     empty_a, (e.cnt == 0));
      chk("a.afull",     af_a,    (e.cnt >= 6 && e.cnt < 8));
      chk("a.aempty",    ae_a,    (e.cnt > 0 && e.cnt <= 2));
      chk("a.data_out",  dout_a,  e.dout);
    end
  end

  // Monitor for the fall-through instance.
  always @(negedge clk) begin : mon_b
    exp_t e;
    while ((exp_b.size() > 0) && (exp_b[0].tag < cyc)) begin
      e = exp_b.pop_front();
      chk("b.wr_ack",    ack_b,   e.wr_ack);
      chk("b.overflow",  ovf_b,   e.ovf);
      chk("b.underflow", udf_b,   e.udf);
      chk("b.count",     count_b, e.cnt);
      chk("b.full",      full_b,  (e.cnt == 5));
      chk("b.empty",     empty_b, (e.cnt == 0));
      chk("b.afull",     af_b,    (e.cnt >= 3 && e.cnt < 5));
      chk("b.aempty",    ae_b,    (e.cnt > 0 && e.cnt <= 1));
      chk("b.data_out",  dout_b,  e.dout);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int pw;
    int pr;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = '0;
    rst_n   = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill past full: almost-full band, full, then overflow.
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 16'(16'hA000 + i));
    step(1'b1, 1'b0, 16'hA009);

    // Drain past empty: ordered data, then underflow with held output.
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 16'h0000);

    // Simultaneous read/write at mid occupancy, at full and at empty.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'(16'hB000 + i));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'(16'hB100 + i));
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'(16'hB200 + i));
    step(1'b1, 1'b1, 16'hBEEF);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 16'h0000);
    step(1'b1, 1'b1, 16'hC001);

    // Reset at occupancy 5, then a fresh write/read round trip.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'(16'hD000 + i));
    do_reset();
    step(1'b1, 1'b0, 16'h1234);
    step(1'b0, 1'b1, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);

    // Fall-through visibility of a single word, then pop back to empty.
    step(1'b1, 1'b0, 16'h0055);
    step(1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);

    // Randomised traffic in write-heavy, read-heavy and balanced phases.
    for (int ph = 0; ph < 6; ph++) begin
      pw = (ph % 3 == 0) ? 75 : (ph % 3 == 1) ? 25 : 50;
      pr = (ph % 3 == 0) ? 25 : (ph % 3 == 1) ? 75 : 50;
      for (int i = 0; i < 80; i++) begin
        step(($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr),
             16'($urandom));
      end
    end

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    #1;
    chk("a.scoreboard_drained", exp_a.size(), 0);
    chk("b.scoreboard_drained", exp_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
